// File: rtl/score_display_ctrl.sv
// Score display sequencer: idle / play / game-over blink / high-score recall.
// Optional high-score tracking is built only when SCORE_DISPLAY_HIGH_SCORE_EN is defined.
module score_display_ctrl #(
  parameter int CLKS_PER_BLINK = 12500000,
  parameter int BLINK_TOGGLES  = 6,
  parameter int MAX_SCORE      = 99
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Game_Start,
  input  logic       i_Score_Inc,
  input  logic       i_Game_Over,
  output logic [7:0] o_Score,
  output logic       o_Blank,
  output logic [7:0] o_High_Score,
  output logic       o_New_High,
  output logic [1:0] o_State
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PLAY       = 2'd1,
    ST_OVER_BLINK = 2'd2,
    ST_SHOW_HIGH  = 2'd3
  } state_t;

  localparam int BLINK_W = $clog2(CLKS_PER_BLINK);
  localparam int TOG_W   = $clog2(BLINK_TOGGLES);

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(CLKS_PER_BLINK - 1);
  localparam logic [TOG_W-1:0]   TOG_LAST   = TOG_W'(BLINK_TOGGLES - 1);
  localparam logic [7:0]         SCORE_MAX  = 8'(MAX_SCORE);

  state_t             state;
  logic [7:0]         score;
  logic [BLINK_W-1:0] blink_cnt;
  logic [TOG_W-1:0]   toggle_cnt;
  logic [7:0]         final_score;
  logic [7:0]         high_val;
  logic               start_game;

  // Same-cycle increment is folded in before the game-over comparison.
  assign final_score = (i_Score_Inc && (score < SCORE_MAX)) ? score + 8'd1 : score;
  assign start_game  = i_Game_Start && (state != ST_PLAY);
  assign o_State     = state;

`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
  localparam state_t AFTER_BLINK = ST_SHOW_HIGH;

  assign high_val = o_High_Score;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_High_Score <= 8'd0;
      o_New_High   <= 1'b0;
    end else if (state == ST_PLAY && i_Game_Over) begin
      // A tie is not a new record.
      if (final_score > o_High_Score) begin
        o_High_Score <= final_score;
        o_New_High   <= 1'b1;
      end
    end else if (start_game) begin
      o_New_High <= 1'b0;
    end
  end
`else
  localparam state_t AFTER_BLINK = ST_IDLE;

  assign high_val     = 8'd0;
  assign o_High_Score = 8'd0;
  assign o_New_High   = 1'b0;
`endif

  // NOTE: all state and output registers use non-blocking assignments so every
  // branch below reads the pre-edge values, independent of statement order.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state      <= ST_IDLE;
      score      <= 8'd0;
      o_Score    <= 8'd0;
      o_Blank    <= 1'b0;
      blink_cnt  <= '0;
      toggle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_Blank <= 1'b0;
          if (i_Game_Start) begin
            state   <= ST_PLAY;
            score   <= 8'd0;
            o_Score <= 8'd0;
          end else begin
            o_Score <= high_val;
          end
        end

        ST_PLAY: begin
          o_Blank <= 1'b0;
          score   <= final_score;
          o_Score <= final_score;
          if (i_Game_Over) begin
            state      <= ST_OVER_BLINK;
            blink_cnt  <= '0;
            toggle_cnt <= '0;
          end
        end

        ST_OVER_BLINK: begin
          if (i_Game_Start) begin
            state     <= ST_PLAY;
            score     <= 8'd0;
            o_Score   <= 8'd0;
            o_Blank   <= 1'b0;
            blink_cnt <= '0;
          end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            o_Blank   <= ~o_Blank;
            if (toggle_cnt == TOG_LAST) begin
              // Even toggle count leaves o_Blank back at 0 here.
              toggle_cnt <= '0;
              state      <= AFTER_BLINK;
              o_Score    <= high_val;
            end else begin
              toggle_cnt <= toggle_cnt + 1'b1;
            end
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end

        ST_SHOW_HIGH: begin
          o_Blank <= 1'b0;
          if (i_Game_Start) begin
            state     <= ST_PLAY;
            score     <= 8'd0;
            o_Score   <= 8'd0;
            blink_cnt <= '0;
          end else if (blink_cnt == BLINK_LAST) begin
            state     <= ST_IDLE;
            blink_cnt <= '0;
            o_Score   <= high_val;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
            o_Score   <= high_val;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with CLKS_PER_BLINK=4, BLINK_TOGGLES=6, MAX_SCORE=99.
// Expectations follow the build's SCORE_DISPLAY_HIGH_SCORE_EN setting.
module tb_score_display_ctrl;

`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Game_Start = 1'b0;
  logic       i_Score_Inc = 1'b0;
  logic       i_Game_Over = 1'b0;
  logic [7:0] o_Score;
  logic       o_Blank;
  logic [7:0] o_High_Score;
  logic       o_New_High;
  logic [1:0] o_State;

  int n_checks = 0;
  int n_pass   = 0;

  score_display_ctrl #(
    .CLKS_PER_BLINK(4),
    .BLINK_TOGGLES (6),
    .MAX_SCORE     (99)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Game_Start(i_Game_Start),
    .i_Score_Inc (i_Score_Inc),
    .i_Game_Over (i_Game_Over),
    .o_Score     (o_Score),
    .o_Blank     (o_Blank),
    .o_High_Score(o_High_Score),
    .o_New_High  (o_New_High),
    .o_State     (o_State)
  );

  always #5 i_Clk = ~i_Clk;

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    logic [7:0] hs3, hs99, nh1, st_after;
    hs3      = HS_EN ? 8'd3 : 8'd0;
    hs99     = HS_EN ? 8'd99 : 8'd0;
    nh1      = HS_EN ? 8'd1 : 8'd0;
    st_after = HS_EN ? 8'd3 : 8'd0;

    // Reset
    tick(); tick();
    i_Reset = 1'b0;
    check("rst_state", 8'(o_State), 8'd0);
    check("rst_score", o_Score, 8'd0);
    check("rst_blank", 8'(o_Blank), 8'd0);
    check("rst_high", o_High_Score, 8'd0);
    check("rst_newhigh", 8'(o_New_High), 8'd0);

    // Increment in IDLE is ignored
    i_Score_Inc = 1'b1; tick(); i_Score_Inc = 1'b0;
    check("idle_inc_state", 8'(o_State), 8'd0);
    check("idle_inc_score", o_Score, 8'd0);

    // Scenario 1: start, three points
    i_Game_Start = 1'b1; tick(); i_Game_Start = 1'b0;
    check("start_state", 8'(o_State), 8'd1);
    for (int i = 0; i < 3; i++) begin
      i_Score_Inc = 1'b1; tick(); i_Score_Inc = 1'b0;
    end
    check("s1_score", o_Score, 8'd3);
    check("s1_state", 8'(o_State), 8'd1);
    check("s1_blank", 8'(o_Blank), 8'd0);

    // Scenario 2: game over at 3, blink six times, recall, idle
    i_Game_Over = 1'b1; tick(); i_Game_Over = 1'b0;
    check("s2_state", 8'(o_State), 8'd2);
    check("s2_high", o_High_Score, hs3);
    check("s2_newhigh", 8'(o_New_High), nh1);
    check("s2_blank0", 8'(o_Blank), 8'd0);
    for (int t = 1; t <= 6; t++) begin
      repeat (3) tick();
      check($sformatf("s2_hold%0d", t), 8'(o_Blank), 8'((t - 1) % 2));
      tick();
      check($sformatf("s2_toggle%0d", t), 8'(o_Blank), 8'(t % 2));
    end
    check("s2_after_state", 8'(o_State), st_after);
    check("s2_after_score", o_Score, hs3);
    repeat (3) tick();
    check("s2_show_state", 8'(o_State), st_after);
    tick();
    check("s2_idle_state", 8'(o_State), 8'd0);
    check("s2_idle_score", o_Score, hs3);

    // Scenario 4a: second game ends at 2, below high score 3
    i_Game_Start = 1'b1; tick(); i_Game_Start = 1'b0;
    check("s4_newhigh_clr", 8'(o_New_High), 8'd0);
    for (int i = 0; i < 2; i++) begin
      i_Score_Inc = 1'b1; tick(); i_Score_Inc = 1'b0;
    end
    i_Game_Over = 1'b1; tick(); i_Game_Over = 1'b0;
    check("s4_state", 8'(o_State), 8'd2);
    check("s4_score", o_Score, 8'd2);
    check("s4_high", o_High_Score, hs3);
    check("s4_newhigh", 8'(o_New_High), 8'd0);

    // Scenario 5: start aborts after two toggles
    repeat (8) tick();
    check("s5_pre_state", 8'(o_State), 8'd2);
    i_Game_Start = 1'b1; tick(); i_Game_Start = 1'b0;
    check("s5_state", 8'(o_State), 8'd1);
    check("s5_score", o_Score, 8'd0);
    check("s5_blank", 8'(o_Blank), 8'd0);

    // Scenario 4b: same-cycle inc + over at 2 ties the high score
    for (int i = 0; i < 2; i++) begin
      i_Score_Inc = 1'b1; tick(); i_Score_Inc = 1'b0;
    end
    check("s4b_pre_score", o_Score, 8'd2);
    i_Score_Inc = 1'b1; i_Game_Over = 1'b1; tick();
    i_Score_Inc = 1'b0; i_Game_Over = 1'b0;
    check("s4b_state", 8'(o_State), 8'd2);
    check("s4b_score", o_Score, 8'd3);
    check("s4b_high", o_High_Score, hs3);
    check("s4b_newhigh", 8'(o_New_High), 8'd0);

    // Scenario 6: reset mid-blink with o_Blank high
    repeat (4) tick();
    check("s6_pre_blank", 8'(o_Blank), 8'd1);
    i_Reset = 1'b1; tick(); i_Reset = 1'b0;
    check("s6_state", 8'(o_State), 8'd0);
    check("s6_blank", 8'(o_Blank), 8'd0);
    check("s6_score", o_Score, 8'd0);
    check("s6_high", o_High_Score, 8'd0);

    // Scenario 3: saturation at 99, then game over with simultaneous start
    i_Game_Start = 1'b1; tick(); i_Game_Start = 1'b0;
    i_Score_Inc = 1'b1;
    repeat (120) tick();
    i_Score_Inc = 1'b0;
    check("s3_score_sat", o_Score, 8'd99);
    i_Game_Start = 1'b1; tick(); i_Game_Start = 1'b0;
    check("s3_start_ignored", 8'(o_State), 8'd1);
    i_Game_Over = 1'b1; i_Game_Start = 1'b1; tick();
    i_Game_Over = 1'b0; i_Game_Start = 1'b0;
    check("s3_over_wins", 8'(o_State), 8'd2);
    check("s3_score", o_Score, 8'd99);
    check("s3_high", o_High_Score, hs99);
    check("s3_newhigh", 8'(o_New_High), nh1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Sequences the score shown on the two-digit seven-segment pair across a game's life: idle, play, game-over blink, high-score recall.
- Owns the running score and the high-score register.
- Drives the 8-bit binary score bus and a blank strobe into the existing units/tens seven-segment decoder.
- Sits between game logic (start, point and game-over pulses) and the display decoder.

Parameters:
- CLKS_PER_BLINK, 12500000, clocks per blink half-period (0.5 s at 25 MHz); minimum 2.
- BLINK_TOGGLES, 6, blank toggles in OVER_BLINK before moving on; must be even and at least 2.
- MAX_SCORE, 99, saturation limit for the score; must be 99 or less (two digits).

Ports:
- i_Clk  in  1  system clock; the only clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Game_Start  in  1  one-cycle pulse: start a new game.
- i_Score_Inc  in  1  one-cycle pulse: add one point.
- i_Game_Over  in  1  one-cycle pulse: game ended.
- o_Score  out  8  binary value for the decoder, range 0..MAX_SCORE.
- o_Blank  out  1  1 = downstream forces all segments off.
- o_High_Score  out  8  best score since reset.
- o_New_High  out  1  1 while the last game set a new high score.
- o_State  out  2  FSM state for debug: 0 IDLE, 1 PLAY, 2 OVER_BLINK, 3 SHOW_HIGH.

Behaviour:
- Registered outputs:
  - All outputs are registered. Each updates on the clock edge after the causing input; latency is 1 cycle.
- Reset (synchronous, checked first and overriding everything, including mid-blink):
  - State goes to IDLE.
  - Internal score, o_Score, o_High_Score, blink counter and toggle counter all go to 0.
  - o_Blank = 0 and o_New_High = 0.
- IDLE:
  - o_Score = o_High_Score, o_Blank = 0.
  - i_Game_Start: go to PLAY, clear score to 0, clear o_New_High.
  - i_Score_Inc and i_Game_Over are ignored.
- PLAY:
  - o_Score = score, o_Blank = 0.
  - i_Score_Inc: score = score + 1, saturating at MAX_SCORE; no wrap.
  - i_Game_Over: go to OVER_BLINK and clear both counters.
  - If i_Score_Inc and i_Game_Over arrive in the same cycle, the increment is applied first. The final score includes it.
  - i_Game_Start is ignored.
- High-score update on PLAY -> OVER_BLINK:
  - If the final score (including any same-cycle increment) is strictly greater than o_High_Score, o_High_Score takes the final score and o_New_High = 1.
  - A tie leaves both unchanged.
- OVER_BLINK:
  - o_Score = final score.
  - The blink counter counts 0..CLKS_PER_BLINK-1.
  - At terminal count, o_Blank toggles and the toggle counter increments.
  - After BLINK_TOGGLES toggles (o_Blank is back to 0), go to SHOW_HIGH and clear the blink counter.
  - i_Score_Inc and i_Game_Over are ignored.
  - i_Game_Start aborts: go to PLAY, score = 0, o_Blank = 0, o_New_High = 0.
- SHOW_HIGH:
  - o_Score = o_High_Score, o_Blank = 0.
  - Holds for one blink half-period (CLKS_PER_BLINK cycles), then goes to IDLE.
  - i_Game_Start goes to PLAY immediately, same as from IDLE.
- Simultaneous inputs:
  - i_Game_Start together with i_Game_Over in PLAY: i_Game_Over wins.
  - Any pulse in a state that does not list it is ignored.
- Width and arithmetic rules:
  - The score is kept in binary. Comparison with o_High_Score is unsigned 8-bit.
  - The decoder performs the digit split; this block must never present a value above MAX_SCORE.

Optional Feature:
- Macro: SCORE_DISPLAY_HIGH_SCORE_EN.
- Defined:
  - Behaviour is exactly as above.
- Undefined:
  - No high-score register is built. o_High_Score and o_New_High are tied to 0.
  - IDLE shows 0.
  - OVER_BLINK goes straight to IDLE after its last toggle; the SHOW_HIGH state code is never entered.

Test Plan:
All scenarios use CLKS_PER_BLINK=4, BLINK_TOGGLES=6, MAX_SCORE=99 and SCORE_DISPLAY_HIGH_SCORE_EN defined.
1. Reset, start, 3 Score_Inc pulses -> o_Score = 3 one cycle after the third pulse; o_State = 1; o_Blank = 0.
2. Score 3, Game_Over -> o_High_Score = 3 and o_New_High = 1. o_Blank toggles every 4 cycles, 6 times. o_State reaches 3, then 0 after 4 more cycles. IDLE shows o_Score = 3.
3. New game, 120 Score_Inc pulses -> o_Score saturates at 99. Game_Over -> o_High_Score = 99.
4. Second game ends at 2 with high score 3 -> o_High_Score stays 3, o_New_High = 0. Same-cycle Inc+Over at score 2 gives final score 3: a tie, no update.
5. Start pulse 2 toggles into OVER_BLINK -> o_State = 1, o_Score = 0, o_Blank = 0 on the next cycle.
6. Reset asserted mid-OVER_BLINK with o_Blank = 1 -> next cycle: o_State = 0, o_Blank = 0, o_Score = 0, o_High_Score = 0.
